// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, reset vector and byte-swap helper
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DATA, HOLD} ifetch_state_t;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/cpu_ifetch.sv
// cpu_ifetch: Avalon-MM instruction fetch master; advances cpu_pc once per delivered instruction.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned PCs via a sticky fetch_err.
module cpu_ifetch #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter bit          BYTE_SWAP    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic        pc_wen_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flush,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        fetch_err
);
    import cpu_pkg::*;
    ifetch_state_t state, nxt;
    logic mis;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic err;
    assign mis = |pc_i[1:0];
    always_ff @(posedge clk or posedge reset)
        if (reset) err <= 1'b0;
        else if (state == ISSUE && mis) err <= 1'b1;
    assign fetch_err = err;
`else
    assign mis = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr_o     <= '0;
            instr_pc_o  <= RESET_VECTOR;
            instr_valid <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DATA && !flush) begin
                instr_o     <= BYTE_SWAP ? bswap32(readdata) : readdata;
                instr_pc_o  <= pc_i;
                instr_valid <= 1'b1;
            end else if (state == HOLD && (flush || instr_ready))
                instr_valid <= 1'b0;
        end
    end
    // A trapped fetch parks in HOLD with nothing valid, so it never leaves until reset
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = ISSUE;
            ISSUE:   nxt = flush ? ISSUE : mis ? HOLD : waitrequest ? ISSUE : DATA;
            DATA:    nxt = flush ? ISSUE : HOLD;
            HOLD:    nxt = (!fetch_err && (flush || (instr_valid && instr_ready))) ? ISSUE : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        read       = state == ISSUE && !mis;
        address    = {pc_i[31:2], 2'b00};
        byteenable = read ? 4'hF : 4'h0;
        pc_wen_o   = state == HOLD && instr_valid && instr_ready && !flush;
    end
endmodule

// File: tb/tb_cpu_ifetch.sv
// tb_cpu_ifetch: directed and randomized checks of cpu_ifetch against a transaction-level model
module tb_cpu_ifetch;
    localparam logic [31:0] RV = 32'hBFC00000;
    logic clk = 1'b0, reset = 1'b1, instr_ready = 1'b0, flush = 1'b0, waitrequest = 1'b0;
    logic [31:0] pc_i = RV, readdata = '0;
    logic pc_wen_o, instr_valid, read, fetch_err;
    logic [31:0] instr_o, instr_pc_o, address;
    logic [3:0] byteenable;
    int tests = 0, fails = 0, wen_cnt = 0, rd_cnt = 0;
    logic exp_valid = 1'b0, pend = 1'b0, prev_rw = 1'b0;
    logic [31:0] exp_pc = RV, prev_addr = '0;

    cpu_ifetch #(.RESET_VECTOR(RV), .BYTE_SWAP(1'b1)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_wen_o(pc_wen_o),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .address(address), .read(read),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == RV) ? 32'h78563412 : (a * 32'h9E3779B1) ^ 32'h1234ABCD;
    endfunction

    function automatic logic [31:0] big_endian(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs after negedge, check, then play slave and cpu_pc at posedge
    task automatic cyc(input logic w, input logic r, input logic f);
        logic acc, wen;
        logic [31:0] a;
        waitrequest = w; instr_ready = r; flush = f;
        #1;
        chk("valid", instr_valid, exp_valid);
        chk("pc_wen", pc_wen_o, exp_valid && r && !f);
        chk("read_with_wen", read && pc_wen_o, 0);
        chk("byteenable", byteenable, read ? 4'hF : 4'h0);
        if (read) chk("address", address, {exp_pc[31:2], 2'b00});
        if (prev_rw) begin
            chk("read_held", read, 1);
            chk("addr_held", address, prev_addr);
        end
        if (exp_valid) begin
            chk("instr_pc", instr_pc_o, exp_pc);
            chk("instr", instr_o, big_endian(mem({exp_pc[31:2], 2'b00})));
        end
        acc = read && !w; wen = pc_wen_o; a = address;
        prev_rw = read && w; prev_addr = address;
        wen_cnt += int'(wen); rd_cnt += int'(read);
        if (exp_valid && r && !f) exp_pc += 4;
        exp_valid = exp_valid ? !(r || f) : (pend && !f);
        pend = acc && !f;
        @(posedge clk); #1;
        if (wen) pc_i = pc_i + 4;
        readdata = acc ? mem(a) : $urandom;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] pc);
        @(negedge clk);
        reset = 1'b1; pc_i = pc; exp_pc = pc;
        exp_valid = 1'b0; pend = 1'b0; prev_rw = 1'b0;
        #1;
        chk("rst_read", read, 0);
        chk("rst_wen", pc_wen_o, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, RV);
        chk("rst_err", fetch_err, 0);
        chk("rst_be", byteenable, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_read", read, 0);
    endtask

    initial begin
        int w0, r0;
        do_reset(RV);
        cyc(1, 0, 0);
        chk("t1_read", read, 1);
        chk("t1_addr", address, RV);
        repeat (4) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t3_instr", instr_o, 32'h12345678);
        chk("t3_pc", instr_pc_o, RV);
        chk("t3_valid", instr_valid, 1);
        w0 = wen_cnt;
        repeat (5) cyc(0, 0, 0);
        chk("t4_no_wen", wen_cnt - w0, 0);
        cyc(0, 1, 0);
        chk("t4_one_wen", wen_cnt - w0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("t5_refetch_read", read, 1);
        chk("t5_refetch_addr", address, RV + 4);
        chk("t5_no_valid", instr_valid, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        w0 = wen_cnt;
        cyc(0, 1, 1);
        chk("t5_flush_wins", wen_cnt - w0, 0);
        chk("t5_flush_valid", instr_valid, 0);
        chk("t5_flush_addr", address, RV + 4);
        w0 = wen_cnt;
        repeat (9) cyc(0, 1, 0);
        chk("throughput", wen_cnt - w0, 3);
        repeat (400) cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        do_reset(32'hBFC00002);
        w0 = wen_cnt; r0 = rd_cnt;
        repeat (8) cyc(0, 1, 0);
        chk("align_err", fetch_err, 1);
        chk("align_no_read", rd_cnt - r0, 0);
        chk("align_no_wen", wen_cnt - w0, 0);
`else
        do_reset(32'hBFC00002);
        w0 = wen_cnt; r0 = rd_cnt;
        repeat (7) cyc(0, 1, 0);
        chk("noalign_err", fetch_err, 0);
        chk("noalign_wen", wen_cnt - w0, 2);
        chk("noalign_reads", rd_cnt - r0, 2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
